// File: rtl/mini_alu_pkg.sv
// Shared definitions for the MiniAlu execution core: opcodes, instruction
// field layout and the decoded-instruction type.
package mini_alu_pkg;

    localparam int INSTR_W = 30;

    // Instruction word layout {op, dst, s1, s0}
    localparam int OP_HI  = 29;
    localparam int OP_LO  = 24;
    localparam int DST_HI = 23;
    localparam int DST_LO = 16;
    localparam int S1_HI  = 15;
    localparam int S1_LO  = 8;
    localparam int S0_HI  = 7;
    localparam int S0_LO  = 0;

    localparam logic [5:0] OP_NOP  = 6'd0;
    localparam logic [5:0] OP_AND  = 6'd1;
    localparam logic [5:0] OP_OR   = 6'd2;
    localparam logic [5:0] OP_NOR  = 6'd3;
    localparam logic [5:0] OP_ADDI = 6'd4;
    localparam logic [5:0] OP_ADD  = 6'd5;
    localparam logic [5:0] OP_SUB  = 6'd6;
    localparam logic [5:0] OP_MUL  = 6'd7;
    localparam logic [5:0] OP_SLL  = 6'd8;
    localparam logic [5:0] OP_SLR  = 6'd9;
    localparam logic [5:0] OP_STO  = 6'd10;
    localparam logic [5:0] OP_BLE  = 6'd11;
    localparam logic [5:0] OP_BEQ  = 6'd12;
    localparam logic [5:0] OP_JMP  = 6'd13;
    localparam logic [5:0] OP_CALL = 6'd14;
    localparam logic [5:0] OP_RET  = 6'd15;
    localparam logic [5:0] OP_PUSH = 6'd16;
    localparam logic [5:0] OP_POP  = 6'd17;
    localparam logic [5:0] OP_LED  = 6'd18;
    localparam logic [5:0] OP_OUT  = 6'd19;
    localparam logic [5:0] OP_IN   = 6'd20;
    localparam logic [5:0] OP_HALT = 6'd21;

    typedef struct packed {
        logic [5:0] op;
        logic [7:0] dst;
        logic [7:0] s1;
        logic [7:0] s0;
    } instr_t;

    // Split a raw ROM word into its fields
    function automatic instr_t decode(input logic [INSTR_W-1:0] w);
        instr_t r;
        r.op  = w[OP_HI:OP_LO];
        r.dst = w[DST_HI:DST_LO];
        r.s1  = w[S1_HI:S1_LO];
        r.s0  = w[S0_HI:S0_LO];
        return r;
    endfunction

endpackage

// File: rtl/mini_alu_core_if.sv
// Generic valid/ready I/O channel between the core and peripheral adapters.
interface mini_alu_core_if #(
    parameter int DATA_W = 16
);
    logic              oIoValid;
    logic              oIoWrite;
    logic [7:0]        oIoChan;
    logic [DATA_W-1:0] oIoData;
    logic              iIoReady;
    logic [DATA_W-1:0] iIoData;

    modport master (
        output oIoValid, oIoWrite, oIoChan, oIoData,
        input  iIoReady, iIoData
    );

    modport slave (
        input  oIoValid, oIoWrite, oIoChan, oIoData,
        output iIoReady, iIoData
    );
endinterface

// File: rtl/mini_alu_stack.sv
// Parametrised LIFO for PUSH/POP/CALL-free stacking. Push while full and pop
// while empty are ignored here; the core flags them.
module mini_alu_stack #(
    parameter int DATA_W      = 16,
    parameter int STACK_DEPTH = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] top_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam int AW = $clog2(STACK_DEPTH);

    logic [DATA_W-1:0] mem_q [STACK_DEPTH];
    logic [AW:0]       sp_q, sp_d;

    assign full_o  = (sp_q == (AW+1)'(STACK_DEPTH));
    assign empty_o = (sp_q == '0);
    assign top_o   = mem_q[sp_q[AW-1:0] - 1'b1];

    // Next stack pointer: push and pop are never requested together
    always_comb begin
        sp_d = sp_q;
        if (push_i && !full_o) begin
            sp_d = sp_q + 1'b1;
        end else if (pop_i && !empty_o) begin
            sp_d = sp_q - 1'b1;
        end
    end

    // Stack pointer register
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Entry storage; contents are don't-care until pushed, so no reset
    always_ff @(posedge Clock) begin
        if (push_i && !full_o) begin
            mem_q[sp_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/mini_alu_core.sv
// MiniAlu execution core: fetch/execute microsequencer with a register file,
// hardware stack, LED register and a stalling valid/ready I/O channel.
module mini_alu_core
    import mini_alu_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int NUM_REGS    = 32,
    parameter int PC_W        = 16,
    parameter int STACK_DEPTH = 16,
    parameter int RA_IDX      = 31
) (
    input  logic               Clock,
    input  logic               Reset,
    output logic [PC_W-1:0]    oIAddr,
    input  logic [INSTR_W-1:0] iInstr,
    mini_alu_core_if.master    io,
    output logic [7:0]         oLed,
    output logic               oStackOvf,
    output logic               oStackUnf,
    output logic               oHalt
);
    localparam int RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [RIDX_W-1:0] RA_R = RIDX_W'(RA_IDX % NUM_REGS);
    localparam logic [31:0] DW32 = DATA_W;

    // Register fields wrap modulo the register count
    function automatic logic [RIDX_W-1:0] ridx(input logic [7:0] f);
        return RIDX_W'(int'(f) % NUM_REGS);
    endfunction

    logic [PC_W-1:0]   pc_q, pc_d;
    instr_t            ir_q, ir_d;
    logic              ir_vld_q, ir_vld_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [7:0]        led_q, led_d;
    logic              ovf_q, ovf_d, unf_q, unf_d, halt_q, halt_d;

    logic [DATA_W-1:0] a, b, wr_data, st_top;
    logic [RIDX_W-1:0] wr_idx;
    logic              wr_en, taken, stall, exec, push, pop, st_full, st_empty;
    logic [PC_W-1:0]   target;

    mini_alu_stack #(.DATA_W(DATA_W), .STACK_DEPTH(STACK_DEPTH)) u_stack (
        .Clock   (Clock),
        .Reset   (Reset),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (b),
        .top_o   (st_top),
        .full_o  (st_full),
        .empty_o (st_empty)
    );

    assign oIAddr      = pc_q;
    assign oLed        = led_q;
    assign oStackOvf   = ovf_q;
    assign oStackUnf   = unf_q;
    assign oHalt       = halt_q;
    assign io.oIoValid = ir_vld_q && !halt_q && (ir_q.op == OP_OUT || ir_q.op == OP_IN);
    assign io.oIoWrite = (ir_q.op == OP_OUT);
    assign io.oIoChan  = ir_q.dst;
    assign io.oIoData  = a;

    // Execute the instruction in IR and decide what fetch does next
    always_comb begin
        a       = regs_q[ridx(ir_q.s1)];
        b       = regs_q[ridx(ir_q.s0)];
        exec    = ir_vld_q && !halt_q;
        wr_en   = 1'b0;
        wr_idx  = ridx(ir_q.dst);
        wr_data = '0;
        taken   = 1'b0;
        target  = pc_q;
        push    = 1'b0;
        pop     = 1'b0;
        stall   = 1'b0;
        led_d   = led_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        halt_d  = halt_q;
        if (exec) begin
            case (ir_q.op)
                OP_AND:  begin wr_en = 1'b1; wr_data = a & b; end
                OP_OR:   begin wr_en = 1'b1; wr_data = a | b; end
                OP_NOR:  begin wr_en = 1'b1; wr_data = ~(a | b); end
                OP_ADDI: begin wr_en = 1'b1; wr_data = a + DATA_W'(ir_q.s0); end
                OP_ADD:  begin wr_en = 1'b1; wr_data = a + b; end
                OP_SUB:  begin wr_en = 1'b1; wr_data = a - b; end
                OP_MUL:  begin wr_en = 1'b1; wr_data = a * b; end
                OP_SLL:  begin wr_en = 1'b1; wr_data = (32'(b) >= DW32) ? '0 : (a << b); end
                OP_SLR:  begin wr_en = 1'b1; wr_data = (32'(b) >= DW32) ? '0 : (a >> b); end
                OP_STO:  begin wr_en = 1'b1; wr_data = DATA_W'({ir_q.s1, ir_q.s0}); end
                OP_BLE:  begin taken = (a <= b); target = PC_W'(ir_q.dst); end
                OP_BEQ:  begin taken = (a == b); target = PC_W'(ir_q.dst); end
                OP_JMP:  begin taken = 1'b1; target = PC_W'(ir_q.dst); end
                OP_CALL: begin
                    taken   = 1'b1;
                    target  = PC_W'(ir_q.dst);
                    wr_en   = 1'b1;
                    wr_idx  = RA_R;
                    wr_data = DATA_W'(pc_q);   // PC already points past the CALL
                end
                OP_RET:  begin taken = 1'b1; target = PC_W'(b); end
                OP_PUSH: begin
                    if (st_full) ovf_d = 1'b1;
                    else         push  = 1'b1;
                end
                OP_POP:  begin
                    wr_en = 1'b1;
                    if (st_empty) begin
                        wr_data = '0;
                        unf_d   = 1'b1;
                    end else begin
                        wr_data = st_top;
                        pop     = 1'b1;
                    end
                end
                OP_LED:  led_d = a[7:0];
                OP_OUT:  stall = !io.iIoReady;
                OP_IN:   begin
                    stall   = !io.iIoReady;
                    wr_en   = io.iIoReady;
                    wr_data = io.iIoData;
                end
                OP_HALT: halt_d = 1'b1;
                default: ;
            endcase
        end
        pc_d     = pc_q;
        ir_d     = ir_q;
        ir_vld_d = ir_vld_q;
        if (!(halt_q || halt_d || stall)) begin
            if (taken) begin
                pc_d     = target;
                ir_vld_d = 1'b0;      // discard the fall-through fetch
            end else begin
                pc_d     = pc_q + 1'b1;
                ir_d     = decode(iInstr);
                ir_vld_d = 1'b1;
            end
        end
    end

    // Architectural state: PC, IR, register file, LED and status flags
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            pc_q     <= '0;
            ir_q     <= '0;
            ir_vld_q <= 1'b0;
            led_q    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            halt_q   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            ir_vld_q <= ir_vld_d;
            led_q    <= led_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            halt_q   <= halt_d;
            if (wr_en) regs_q[wr_idx] <= wr_data;
        end
    end

endmodule

// File: tb/tb_mini_alu_core.sv
// Bench for mini_alu_core: small programs in a combinational ROM, OUT traffic
// checked against a scoreboard of expected {channel, data} pairs.
module tb_mini_alu_core;
    import mini_alu_pkg::*;

    localparam int DW  = 16;
    localparam int PCW = 16;

    logic               Clock = 1'b0;
    logic               Reset = 1'b0;
    logic [PCW-1:0]     iaddr;
    logic [INSTR_W-1:0] instr;
    logic [7:0]         led;
    logic               ovf, unf, halt;
    logic [INSTR_W-1:0] rom [256];

    int          n_cmp = 0;
    int          n_err = 0;
    logic [23:0] sb [$];
    logic [23:0] sb_e;

    mini_alu_core_if #(.DATA_W(DW)) io ();

    mini_alu_core #(
        .DATA_W(DW), .NUM_REGS(32), .PC_W(PCW), .STACK_DEPTH(2), .RA_IDX(31)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .oIAddr    (iaddr),
        .iInstr    (instr),
        .io        (io),
        .oLed      (led),
        .oStackOvf (ovf),
        .oStackUnf (unf),
        .oHalt     (halt)
    );

    assign instr = (iaddr < 16'd256) ? rom[iaddr[7:0]] : '0;

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [INSTR_W-1:0] ins(input logic [5:0] op, input logic [7:0] d,
                                               input logic [7:0] s1, input logic [7:0] s0);
        return {op, d, s1, s0};
    endfunction

    function automatic logic [INSTR_W-1:0] sto(input logic [7:0] d, input logic [15:0] v);
        return {OP_STO, d, v[15:8], v[7:0]};
    endfunction

    function automatic logic [INSTR_W-1:0] out(input logic [7:0] ch, input logic [7:0] r);
        return {OP_OUT, ch, r, 8'h00};
    endfunction

    // Completed OUT transfers are popped from the scoreboard
    always @(negedge Clock) begin
        if (io.oIoValid && io.iIoReady && io.oIoWrite) begin
            if (sb.size() == 0) begin
                chk("sb_extra_out", {8'h00, io.oIoChan, io.oIoData}, 32'hFFFF_FFFF);
            end else begin
                sb_e = sb.pop_front();
                chk("sb_out", {8'h00, io.oIoChan, io.oIoData}, {8'h00, sb_e});
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic begin_prog();
        Reset = 1'b0;
        sb.delete();
        for (int i = 0; i < 256; i++) rom[i] = '0;
    endtask

    task automatic release_reset();
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
    endtask

    task automatic run_halt();
        for (int i = 0; i < 300 && !halt; i++) tick();
        chk("halt_reached", halt, 1'b1);
        chk("sb_drain", sb.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        io.iIoReady = 1'b1;
        io.iIoData  = 16'h5A5A;

        // ---- Program 1: arithmetic, shifts, LED, reset state
        begin_prog();
        rom[0]  = sto(1, 16'h0005);
        rom[1]  = sto(2, 16'h0003);
        rom[2]  = ins(OP_SUB, 3, 1, 2);
        rom[3]  = ins(OP_LED, 0, 3, 0);
        rom[4]  = out(1, 3);              sb.push_back({8'd1,  16'h0002});
        rom[5]  = sto(1, 16'hFFFF);
        rom[6]  = ins(OP_ADDI, 2, 1, 1);
        rom[7]  = out(2, 2);              sb.push_back({8'd2,  16'h0000});
        rom[8]  = sto(4, 16'd16);
        rom[9]  = ins(OP_SLL, 3, 1, 4);
        rom[10] = out(3, 3);              sb.push_back({8'd3,  16'h0000});
        rom[11] = sto(6, 16'd4);
        rom[12] = ins(OP_SLR, 5, 1, 6);
        rom[13] = out(4, 5);              sb.push_back({8'd4,  16'h0FFF});
        rom[14] = sto(7, 16'h1234);
        rom[15] = sto(8, 16'h00F0);
        rom[16] = ins(OP_AND, 9, 7, 8);
        rom[17] = out(5, 9);              sb.push_back({8'd5,  16'h0030});
        rom[18] = ins(OP_OR, 9, 7, 8);
        rom[19] = out(6, 9);              sb.push_back({8'd6,  16'h12F4});
        rom[20] = ins(OP_NOR, 9, 7, 8);
        rom[21] = out(7, 9);              sb.push_back({8'd7,  16'hED0B});
        rom[22] = ins(OP_ADD, 9, 1, 7);
        rom[23] = out(8, 9);              sb.push_back({8'd8,  16'h1233});
        rom[24] = ins(OP_MUL, 9, 7, 8);
        rom[25] = out(9, 9);              sb.push_back({8'd9,  16'h10C0});
        rom[26] = ins(OP_SUB, 9, 8, 7);
        rom[27] = out(10, 9);             sb.push_back({8'd10, 16'hEEBC});
        rom[28] = ins(6'h3F, 9, 1, 1);
        rom[29] = out(11, 9);             sb.push_back({8'd11, 16'hEEBC});
        rom[30] = ins(OP_SLL, 9, 7, 6);
        rom[31] = out(12, 9);             sb.push_back({8'd12, 16'h2340});
        rom[32] = ins(OP_HALT, 0, 0, 0);
        rom[33] = out(8'hEE, 1);
        tick();
        chk("rst_iaddr", iaddr, 0);
        chk("rst_led", led, 0);
        chk("rst_halt", halt, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_unf", unf, 0);
        chk("rst_valid", io.oIoValid, 0);
        release_reset();
        repeat (4) tick();
        chk("led_before", led, 8'h00);
        tick();
        chk("led_sub", led, 8'h02);
        run_halt();
        chk("led_held", led, 8'h02);

        // ---- Program 2: branches, CALL/RET
        begin_prog();
        rom[0]  = sto(1, 16'd3);
        rom[1]  = sto(2, 16'd3);
        rom[2]  = ins(OP_BLE, 8'd10, 1, 2);
        rom[3]  = out(8'hEE, 1);
        rom[4]  = ins(OP_HALT, 0, 0, 0);
        rom[5]  = ins(OP_CALL, 8'd20, 0, 0);
        rom[6]  = out(7, 31);
        rom[7]  = ins(OP_HALT, 0, 0, 0);
        rom[10] = out(5, 1);
        rom[11] = sto(3, 16'd5);
        rom[12] = sto(4, 16'hFFFF);
        rom[13] = ins(OP_BLE, 8'd40, 4, 1);
        rom[14] = ins(OP_BLE, 8'd40, 3, 1);
        rom[15] = ins(OP_BEQ, 8'd40, 1, 3);
        rom[16] = out(6, 3);
        rom[17] = ins(OP_JMP, 8'd5, 0, 0);
        rom[18] = out(8'hEE, 2);
        rom[20] = out(8, 31);
        rom[21] = ins(OP_RET, 0, 0, 31);
        rom[22] = out(8'hEE, 3);
        rom[40] = out(8'hEE, 4);
        sb.push_back({8'd5, 16'd3});
        sb.push_back({8'd6, 16'd5});
        sb.push_back({8'd8, 16'd6});
        sb.push_back({8'd7, 16'd6});
        release_reset();
        repeat (3) tick();
        chk("ble_fallthru_addr", iaddr, 3);
        tick();
        chk("ble_target_addr", iaddr, 10);
        chk("ble_bubble", io.oIoValid, 0);
        tick();
        chk("ble_target_valid", io.oIoValid, 1);
        chk("ble_next_addr", iaddr, 11);
        run_halt();

        // ---- Program 3: stack overflow / underflow with depth 2
        begin_prog();
        rom[0]  = sto(1, 16'h0011);
        rom[1]  = sto(2, 16'h0022);
        rom[2]  = sto(3, 16'h0033);
        rom[3]  = sto(12, 16'h0055);
        rom[4]  = ins(OP_PUSH, 0, 0, 1);
        rom[5]  = ins(OP_PUSH, 0, 0, 2);
        rom[6]  = ins(OP_PUSH, 0, 0, 3);
        rom[7]  = ins(OP_POP, 10, 0, 0);
        rom[8]  = ins(OP_POP, 11, 0, 0);
        rom[9]  = ins(OP_POP, 12, 0, 0);
        rom[10] = out(10, 10);
        rom[11] = out(11, 11);
        rom[12] = out(12, 12);
        rom[13] = ins(OP_HALT, 0, 0, 0);
        sb.push_back({8'd10, 16'h0022});
        sb.push_back({8'd11, 16'h0011});
        sb.push_back({8'd12, 16'h0000});
        release_reset();
        repeat (7) tick();
        chk("ovf_before", ovf, 0);
        tick();
        chk("ovf_third_push", ovf, 1);
        chk("unf_not_yet", unf, 0);
        repeat (3) tick();
        chk("unf_third_pop", unf, 1);
        run_halt();
        chk("ovf_sticky", ovf, 1);

        // ---- Program 4: OUT stall, IN read
        begin_prog();
        io.iIoReady = 1'b0;
        rom[0] = sto(1, 16'hABCD);
        rom[1] = out(3, 1);
        rom[2] = ins(OP_IN, 2, 0, 0);
        rom[3] = out(9, 2);
        rom[4] = ins(OP_HALT, 0, 0, 0);
        sb.push_back({8'd3, 16'hABCD});
        sb.push_back({8'd9, 16'h5A5A});
        release_reset();
        repeat (2) tick();
        for (int c = 0; c < 6; c++) begin
            chk("stall_valid", io.oIoValid, 1);
            chk("stall_data", io.oIoData, 16'hABCD);
            chk("stall_chan", io.oIoChan, 3);
            chk("stall_pc", iaddr, 2);
            if (c < 5) tick();
        end
        chk("stall_write", io.oIoWrite, 1);
        io.iIoReady = 1'b1;
        tick();
        chk("out_done_pc", iaddr, 3);
        run_halt();

        // ---- Program 5: async reset mid-stall, restart, HALT freeze
        begin_prog();
        io.iIoReady = 1'b0;
        rom[0] = sto(1, 16'hABCD);
        rom[1] = out(3, 1);
        rom[2] = ins(OP_HALT, 0, 0, 0);
        release_reset();
        repeat (2) tick();
        chk("pre_rst_valid", io.oIoValid, 1);
        #1;
        Reset = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = '0;
        rom[0] = out(1, 1);
        rom[1] = ins(OP_HALT, 0, 0, 0);
        rom[2] = out(8'hEE, 1);
        sb.delete();
        sb.push_back({8'd1, 16'h0000});
        #1;
        chk("async_rst_valid", io.oIoValid, 0);
        chk("async_rst_pc", iaddr, 0);
        Reset = 1'b1;
        io.iIoReady = 1'b1;
        run_halt();
        for (int c = 0; c < 4; c++) begin
            chk("halt_pc_frozen", iaddr, 2);
            tick();
        end
        chk("halt_held", halt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
